// File: rtl/anmux_adc_scanner.sv
// Scans DG408 mux channels from a mask. Each channel gets one ADC128S022 frame, and its
// 12-bit result is buffered for readback by the MCU.
module anmux_adc_scanner #(
    parameter int unsigned SCLK_DIV      = 13,
    parameter int unsigned SETTLE_CYCLES = 500,
    parameter int unsigned ADC_IN        = 0
) (
    input  logic        sysclk,
    input  logic        sysreset_n,
    input  logic [7:0]  cmd_mask,
    input  logic        cmd_start,
    input  logic        cmd_continuous,
    input  logic        cmd_stop,
    input  logic [2:0]  rd_sel,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic [3:0]  anmux_ctrl,
    output logic        ADC_CS_N,
    output logic        ADC_SCLK,
    output logic        ADC_SADDR,
    input  logic        ADC_SDAT
);

    typedef enum logic [2:0] {
        StPrime, StIdle, StSelect, StSettle, StConvert, StStore
    } state_e;

    localparam logic [7:0]  DivLast    = 8'(SCLK_DIV - 1);
    localparam logic [15:0] SettleLoad = (SETTLE_CYCLES > 1) ? 16'(SETTLE_CYCLES - 2) : 16'd0;
    localparam logic [7:0]  CtrlByte   = {2'b00, 3'(ADC_IN), 3'b000};
    localparam logic [5:0]  PhLast     = 6'd33;

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  ph_q, ph_d;
    logic [15:0] settle_q, settle_d;
    logic [7:0]  mask_q, mask_d;
    logic        cont_q, cont_d;
    logic        stop_q, stop_d;
    logic [2:0]  chan_q, chan_d;
    logic        done_q, done_d;
    logic [3:0]  anmux_q, anmux_d;
    logic        start_prev_q, start_pulse_q;
    logic [11:0] shift_q;
    logic [15:0] rbuf_q [8];
    logic        cs_n_q, sclk_q, saddr_q;
    logic        cs_n_d, sclk_d, saddr_d;
    logic        in_frame, frame_last, sample_en, accept, store_en, stop_now;
    logic [7:0]  higher;
    logic [2:0]  bit_idx;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

    assign in_frame   = (state_q == StPrime) || (state_q == StConvert);
    assign frame_last = in_frame && (div_q == DivLast) && (ph_q == PhLast);
    // Phase 2p+1 is the low half of SCLK period p; its rising edge opens phase 2p+2.
    assign sample_en  = in_frame && (div_q == 8'd0) && !ph_q[0] && (ph_q >= 6'd2)
                        && (ph_q <= 6'd32);
    assign higher     = mask_q & (8'hFE << chan_q);
    assign stop_now   = stop_q | cmd_stop;
    assign bit_idx    = 3'((ph_q - 6'd1) >> 1);

    assign busy       = (state_q != StPrime) && (state_q != StIdle);
    assign done       = done_q;
    assign anmux_ctrl = anmux_q;
    assign ADC_CS_N   = cs_n_q;
    assign ADC_SCLK   = sclk_q;
    assign ADC_SADDR  = saddr_q;
    assign rd_data    = rbuf_q[rd_sel];

    always_comb begin
        state_d  = state_q;
        div_d    = 8'd0;
        ph_d     = 6'd0;
        settle_d = settle_q;
        mask_d   = mask_q;
        cont_d   = cont_q;
        stop_d   = stop_q | (cmd_stop & busy);
        chan_d   = chan_q;
        done_d   = done_q;
        anmux_d  = anmux_q;
        accept   = 1'b0;
        store_en = 1'b0;

        if (in_frame && !frame_last) begin
            if (div_q == DivLast) begin
                ph_d = ph_q + 6'd1;
            end else begin
                div_d = div_q + 8'd1;
                ph_d  = ph_q;
            end
        end

        unique case (state_q)
            StPrime: begin
                anmux_d = 4'b0000;
                if (frame_last) state_d = StIdle;
            end
            StIdle: begin
                anmux_d = 4'b0000;
                if (start_pulse_q && (cmd_mask != 8'd0)) begin
                    accept  = 1'b1;
                    mask_d  = cmd_mask;
                    cont_d  = cmd_continuous;
                    stop_d  = 1'b0;
                    done_d  = 1'b0;
                    chan_d  = lowest_bit(cmd_mask);
                    state_d = StSelect;
                end
            end
            StSelect: begin
                anmux_d  = {1'b1, chan_q};
                settle_d = SettleLoad;
                state_d  = (SETTLE_CYCLES > 1) ? StSettle : StConvert;
            end
            StSettle: begin
                // The select cycle already counts as one settling cycle.
                if (settle_q == 16'd0) state_d = StConvert;
                else                   settle_d = settle_q - 16'd1;
            end
            StConvert: begin
                if (frame_last) state_d = StStore;
            end
            StStore: begin
                store_en = 1'b1;
                if (|higher) begin
                    if (stop_now) begin
                        state_d = StIdle;
                    end else begin
                        chan_d  = lowest_bit(higher);
                        state_d = StSelect;
                    end
                end else begin
                    done_d = 1'b1;
                    if (cont_q && !stop_now) begin
                        chan_d  = lowest_bit(mask_q);
                        state_d = StSelect;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StPrime;
        endcase
    end

    // Pin drivers are registered from the current counters, so every frame edge lags by one cycle.
    always_comb begin
        cs_n_d  = !in_frame;
        sclk_d  = !(in_frame && ph_q[0] && (ph_q <= 6'd31));
        saddr_d = in_frame && (ph_q >= 6'd1) && (ph_q <= 6'd16) && CtrlByte[3'd7 - bit_idx];
    end

    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            state_q       <= StPrime;
            div_q         <= 8'd0;
            ph_q          <= 6'd0;
            settle_q      <= 16'd0;
            mask_q        <= 8'd0;
            cont_q        <= 1'b0;
            stop_q        <= 1'b0;
            chan_q        <= 3'd0;
            done_q        <= 1'b0;
            anmux_q       <= 4'b0000;
            start_prev_q  <= 1'b0;
            start_pulse_q <= 1'b0;
            shift_q       <= 12'd0;
            cs_n_q        <= 1'b1;
            sclk_q        <= 1'b1;
            saddr_q       <= 1'b0;
            for (int i = 0; i < 8; i++) rbuf_q[i] <= 16'd0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            ph_q          <= ph_d;
            settle_q      <= settle_d;
            mask_q        <= mask_d;
            cont_q        <= cont_d;
            stop_q        <= stop_d;
            chan_q        <= chan_d;
            done_q        <= done_d;
            anmux_q       <= anmux_d;
            start_prev_q  <= cmd_start;
            start_pulse_q <= cmd_start & ~start_prev_q;
            cs_n_q        <= cs_n_d;
            sclk_q        <= sclk_d;
            saddr_q       <= saddr_d;
            // Only the last 12 of 16 bits survive, which drops the four leading zeros.
            if (sample_en) shift_q <= {shift_q[10:0], ADC_SDAT};
            if (accept) begin
                for (int i = 0; i < 8; i++) rbuf_q[i][15] <= 1'b0;
            end else if (store_en) begin
                rbuf_q[chan_q] <= {1'b1, chan_q, shift_q};
            end
        end
    end

endmodule

// File: tb/tb_anmux_adc_scanner.sv
// Directed bench for anmux_adc_scanner, using a behavioural ADC128S022 that shifts out a
// queued 12-bit value on each SCLK falling edge.
module tb_anmux_adc_scanner;

    logic        sysclk = 1'b0;
    logic        sysreset_n;
    logic [7:0]  cmd_mask;
    logic        cmd_start, cmd_continuous, cmd_stop;
    logic [2:0]  rd_sel;
    logic [15:0] rd_data;
    logic        busy, done;
    logic [3:0]  anmux_ctrl;
    logic        ADC_CS_N, ADC_SCLK, ADC_SADDR;
    logic        ADC_SDAT = 1'b0;

    int passed = 0;
    int total  = 0;

    logic [11:0] adc_q [$];
    logic [11:0] adc_default = 12'hA5C;
    logic [15:0] adc_word = 16'd0;
    int          adc_bit = 0;

    always #10 sysclk = ~sysclk;

    anmux_adc_scanner #(
        .SCLK_DIV      (2),
        .SETTLE_CYCLES (4),
        .ADC_IN        (3)
    ) dut (
        .sysclk         (sysclk),
        .sysreset_n     (sysreset_n),
        .cmd_mask       (cmd_mask),
        .cmd_start      (cmd_start),
        .cmd_continuous (cmd_continuous),
        .cmd_stop       (cmd_stop),
        .rd_sel         (rd_sel),
        .rd_data        (rd_data),
        .busy           (busy),
        .done           (done),
        .anmux_ctrl     (anmux_ctrl),
        .ADC_CS_N       (ADC_CS_N),
        .ADC_SCLK       (ADC_SCLK),
        .ADC_SADDR      (ADC_SADDR),
        .ADC_SDAT       (ADC_SDAT)
    );

    always @(negedge ADC_CS_N) begin
        if (adc_q.size() > 0) adc_word = {4'h0, adc_q.pop_front()};
        else                  adc_word = {4'h0, adc_default};
        adc_bit = 0;
    end

    always @(negedge ADC_SCLK) begin
        if (!ADC_CS_N && adc_bit < 16) begin
            ADC_SDAT = adc_word[15 - adc_bit];
            adc_bit++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_rd(input string tag, input logic [2:0] idx, input logic [15:0] exp);
        rd_sel = idx;
        #1;
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic valid_vec(output logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            rd_sel = 3'(i);
            #1;
            v[i] = rd_data[15];
        end
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1;
        @(negedge sysclk);
        @(negedge sysclk);
        cmd_start = 1'b0;
    endtask

    task automatic wait_cs_low(input int budget, output bit ok);
        int n = 0;
        while (ADC_CS_N !== 1'b0 && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        ok = (ADC_CS_N === 1'b0);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic wait_anmux(input logic [3:0] v, input int budget, output bit ok);
        int n = 0;
        while (anmux_ctrl !== v && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        ok = (anmux_ctrl === v);
    endtask

    task automatic wait_rd(input logic [15:0] v, input int budget, output bit ok);
        int n = 0;
        while (rd_data !== v && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        ok = (rd_data === v);
    endtask

    // Cycles with CS high, counted from the first cycle the new mux select is visible.
    task automatic settle_gap(output int n);
        n = 0;
        while (ADC_CS_N === 1'b1 && n < 100) begin
            n++;
            @(negedge sysclk);
        end
    endtask

    task automatic frame_watch(output int low_cnt, output logic [7:0] cbyte, output int periods);
        logic prev;
        low_cnt = 0;
        cbyte   = 8'd0;
        periods = 0;
        prev    = 1'b1;
        while (ADC_CS_N === 1'b0 && low_cnt < 200) begin
            if (!prev && ADC_SCLK) begin
                if (periods < 8) cbyte = {cbyte[6:0], ADC_SADDR};
                periods++;
            end
            prev = ADC_SCLK;
            low_cnt++;
            @(negedge sysclk);
        end
    endtask

    initial begin
        bit          ok;
        int          low_cnt, periods, gap, falls;
        logic [7:0]  cbyte, vv;
        logic        prev;

        sysreset_n     = 1'b0;
        cmd_mask       = 8'd0;
        cmd_start      = 1'b0;
        cmd_continuous = 1'b0;
        cmd_stop       = 1'b0;
        rd_sel         = 3'd0;

        // 1: reset values, then the priming frame
        @(negedge sysclk);
        @(negedge sysclk);
        chk("rst_cs_n", 32'(ADC_CS_N), 32'd1);
        chk("rst_sclk", 32'(ADC_SCLK), 32'd1);
        chk("rst_saddr", 32'(ADC_SADDR), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_anmux", 32'(anmux_ctrl), 32'd0);
        sysreset_n = 1'b1;
        wait_cs_low(20, ok);
        chk("prime_cs_seen", 32'(ok), 32'd1);
        frame_watch(low_cnt, cbyte, periods);
        chk("prime_cs_len", 32'(low_cnt), 32'd68);
        chk("prime_ctrl", 32'(cbyte), 32'h18);
        chk("prime_periods", 32'(periods), 32'd16);
        repeat (3) @(negedge sysclk);
        chk("prime_idle_busy", 32'(busy), 32'd0);
        valid_vec(vv);
        chk("prime_valid", 32'(vv), 32'd0);

        // 2: one-shot scan of channels 0, 2, 7
        @(negedge sysclk);
        cmd_mask = 8'b1000_0101;
        pulse_start();
        wait_anmux(4'b1000, 50, ok);
        chk("s2_mux0", 32'(ok), 32'd1);
        settle_gap(gap);
        chk("s2_gap0", 32'(gap), 32'd4);
        wait_anmux(4'b1010, 200, ok);
        chk("s2_mux2", 32'(ok), 32'd1);
        settle_gap(gap);
        chk("s2_gap2", 32'(gap), 32'd4);
        wait_anmux(4'b1111, 200, ok);
        chk("s2_mux7", 32'(ok), 32'd1);
        settle_gap(gap);
        chk("s2_gap7", 32'(gap), 32'd4);
        wait_idle(200, ok);
        chk("s2_idle", 32'(ok), 32'd1);
        @(negedge sysclk);
        chk("s2_done", 32'(done), 32'd1);
        chk("s2_anmux_off", 32'(anmux_ctrl), 32'd0);
        chk_rd("s2_rd0", 3'd0, 16'h8A5C);
        chk_rd("s2_rd1", 3'd1, 16'h0000);
        chk_rd("s2_rd2", 3'd2, 16'hAA5C);
        chk_rd("s2_rd7", 3'd7, 16'hFA5C);

        // 3: start with empty mask, then start while busy
        @(negedge sysclk);
        cmd_mask = 8'd0;
        pulse_start();
        repeat (6) @(negedge sysclk);
        chk("s3_mask0_busy", 32'(busy), 32'd0);
        chk("s3_mask0_done", 32'(done), 32'd1);
        cmd_mask = 8'b0000_0010;
        pulse_start();
        wait_anmux(4'b1001, 50, ok);
        chk("s3_mux1", 32'(ok), 32'd1);
        chk("s3_done_clr", 32'(done), 32'd0);
        cmd_mask = 8'b0100_0000;
        pulse_start();
        chk("s3_busy_held", 32'(busy), 32'd1);
        wait_idle(300, ok);
        chk("s3_idle", 32'(ok), 32'd1);
        @(negedge sysclk);
        chk("s3_done", 32'(done), 32'd1);
        chk_rd("s3_rd1", 3'd1, 16'h9A5C);
        chk_rd("s3_rd6", 3'd6, 16'h0000);
        chk_rd("s3_rd0_invalid", 3'd0, 16'h0A5C);

        // 4: continuous single channel, stop raised during settle
        @(negedge sysclk);
        adc_q.push_back(12'h123);
        adc_q.push_back(12'h456);
        adc_default    = 12'h789;
        cmd_mask       = 8'b0001_0000;
        cmd_continuous = 1'b1;
        rd_sel         = 3'd4;
        pulse_start();
        wait_rd(16'hC123, 300, ok);
        chk("s4_first", 32'(ok), 32'd1);
        wait_rd(16'hC456, 300, ok);
        chk("s4_second", 32'(ok), 32'd1);
        chk("s4_busy_wrap", 32'(busy), 32'd1);
        repeat (2) @(negedge sysclk);
        cmd_stop = 1'b1;
        wait_idle(300, ok);
        chk("s4_idle", 32'(ok), 32'd1);
        chk_rd("s4_third", 3'd4, 16'hC789);
        chk("s4_done", 32'(done), 32'd1);
        cmd_stop       = 1'b0;
        cmd_continuous = 1'b0;

        // 5: reset during SCLK period 7 of a conversion frame
        @(negedge sysclk);
        adc_default    = 12'h3C3;
        cmd_mask       = 8'b0000_0001;
        cmd_continuous = 1'b1;
        rd_sel         = 3'd0;
        pulse_start();
        wait_rd(16'h83C3, 300, ok);
        chk("s5_first_store", 32'(ok), 32'd1);
        chk("s5_done_pre", 32'(done), 32'd1);
        wait_cs_low(50, ok);
        chk("s5_frame2", 32'(ok), 32'd1);
        falls = 0;
        prev  = ADC_SCLK;
        while (falls < 8 && ADC_CS_N === 1'b0) begin
            @(negedge sysclk);
            if (prev && !ADC_SCLK) falls++;
            prev = ADC_SCLK;
        end
        chk("s5_period7", 32'(falls), 32'd8);
        sysreset_n = 1'b0;
        @(negedge sysclk);
        chk("s5_cs_n", 32'(ADC_CS_N), 32'd1);
        chk("s5_sclk", 32'(ADC_SCLK), 32'd1);
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_done", 32'(done), 32'd0);
        chk("s5_anmux", 32'(anmux_ctrl), 32'd0);
        valid_vec(vv);
        chk("s5_valid", 32'(vv), 32'd0);
        @(negedge sysclk);
        cmd_continuous = 1'b0;
        sysreset_n     = 1'b1;
        cmd_start      = 1'b1;
        wait_cs_low(20, ok);
        chk("s5_prime_seen", 32'(ok), 32'd1);
        frame_watch(low_cnt, cbyte, periods);
        chk("s5_prime_len", 32'(low_cnt), 32'd68);
        chk("s5_prime_ctrl", 32'(cbyte), 32'h18);
        repeat (4) @(negedge sysclk);
        chk("s5_start_ignored", 32'(busy), 32'd0);
        cmd_start = 1'b0;

        // 6: distinct per-frame values on channels 0..2
        @(negedge sysclk);
        adc_q.push_back(12'h001);
        adc_q.push_back(12'hFFF);
        adc_q.push_back(12'h800);
        cmd_mask = 8'b0000_0111;
        pulse_start();
        chk("s6_busy", 32'(busy), 32'd1);
        wait_idle(500, ok);
        chk("s6_idle", 32'(ok), 32'd1);
        chk_rd("s6_rd0", 3'd0, 16'h8001);
        chk_rd("s6_rd1", 3'd1, 16'h9FFF);
        chk_rd("s6_rd2", 3'd2, 16'hA800);
        chk("s6_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
